// File: rtl/rd_burst_pkg.sv
// Shared definitions for the burst read controller: FSM state encoding and
// the retry-counter width helper.
package rd_burst_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    DLY  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Width needed to hold a retry count up to and including max_retry.
  function automatic int retry_width(input int max_retry);
    return $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/rd_burst_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero when decremented.
module rd_burst_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rd_burst_ctrl.sv
// Burst read sequencer: issues burst_len+1 reads from a latched start address,
// with a per-beat delay, wait-state re-issue and a retry-exhausted error exit.
module rd_burst_ctrl
  import rd_burst_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BURST_W   = 4,
  parameter int WAIT_W    = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [WAIT_W-1:0] wait_cyc,
  input  logic              ws,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic              dv,
  output logic              ds,
  output logic              err,
  output logic              busy
);

  localparam int RETRY_W = retry_width(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_e              state_q, state_d;
  logic                rd_q, rd_d;
  logic                dv_q, dv_d;
  logic                ds_q, ds_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;

  logic dly_load, dly_dec, dly_zero;
  logic beats_load, beats_dec, beats_zero;

  rd_burst_cnt #(.W(WAIT_W)) u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (wait_q),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  rd_burst_cnt #(.W(BURST_W)) u_beats_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (beats_load),
    .load_val (burst_len),
    .dec      (beats_dec),
    .zero     (beats_zero)
  );

  // Outputs are decoded from the next state so they appear with the state.
  always_comb begin
    state_d    = state_q;
    rd_d       = 1'b0;
    dv_d       = 1'b0;
    ds_d       = 1'b0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    addr_d     = addr_q;
    wait_d     = wait_q;
    retry_d    = retry_q;
    dly_load   = 1'b0;
    dly_dec    = 1'b0;
    beats_load = 1'b0;
    beats_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = READ;
          addr_d     = start_addr;
          wait_d     = wait_cyc;
          retry_d    = '0;
          beats_load = 1'b1;
          rd_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end

      READ: begin
        dly_load = 1'b1;
        state_d  = DLY;
        rd_d     = 1'b1;
        busy_d   = 1'b1;
      end

      DLY: begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
        if (!dly_zero) begin
          dly_dec = 1'b1;
        end else if (ws) begin
          if (retry_q == RETRY_LAST) begin
            state_d = ERR;
            rd_d    = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = READ;
            retry_d = retry_q + 1'b1;
          end
        end else begin
          dv_d    = 1'b1;
          retry_d = '0;
          if (beats_zero) begin
            state_d = DONE;
            rd_d    = 1'b0;
            ds_d    = 1'b1;
          end else begin
            state_d   = READ;
            beats_dec = 1'b1;
            addr_d    = addr_q + 1'b1;
          end
        end
      end

      DONE: state_d = IDLE;

      ERR: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      dv_q    <= 1'b0;
      ds_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wait_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      dv_q    <= dv_d;
      ds_q    <= ds_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
    end
  end

  assign rd   = rd_q;
  assign addr = addr_q;
  assign dv   = dv_q;
  assign ds   = ds_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule
